divider_scheduler: RTL and testbench
====================================

# divider_scheduler

Shares one 16-bit signed serial divider between two requester channels, so that C processes no longer need a private divider each. Each channel presents a dividend/divisor pair over a stb/ack input handshake. The block arbitrates round-robin, runs a 16-iteration restoring division and returns quotient and remainder over a stb/ack output handshake on the same channel. Only one operation is in flight at a time.

## Interface
- No parameters. Widths are fixed at 16 bits and the channel count at 2.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- input_dividend_0 / input_dividend_1  input  16  signed dividend, channel n
- input_divisor_0 / input_divisor_1  input  16  signed divisor, channel n
- input_0_stb / input_1_stb  input  1  operand pair valid, channel n
- input_0_ack / input_1_ack  output  1  operands accepted, channel n (registered)
- output_quotient_0 / output_quotient_1  output  16  signed quotient, channel n
- output_remainder_0 / output_remainder_1  output  16  signed remainder, channel n
- output_0_stb / output_1_stb  output  1  result valid, channel n (registered)
- output_0_ack / output_1_ack  input  1  result taken, channel n
- busy  output  1  high in every state except ARB

## Operation
- Handshake rule: a transfer occurs on a rising edge where stb and ack are both high.
  - Senders hold stb and data stable until that edge.
  - Receivers may hold ack high in advance.
- States: ARB, ACK, CALC, FIX, RESULT.
- ARB:
  - If exactly one input_n_stb is high, grant n.
  - If both are high, grant the channel not served last. The last-served pointer resets to 1, so channel 0 wins the first tie.
  - On a grant, register grant, set input_grant_ack=1 and go to ACK.
  - With no request, stay in ARB.
- ACK:
  - Capture operands on the edge. Ack is high for exactly this one cycle.
  - Load |dividend| and |divisor|, the quotient sign (dividend[15]^divisor[15]) and the remainder sign (dividend[15]).
  - Clear the partial remainder, set count=15, clear ack and go to CALC.
- CALC, one restoring step per cycle, 16 cycles:
  - Shift the next dividend MSB into the 17-bit partial remainder.
  - If the partial remainder ≥ |divisor|, subtract and shift 1 into the quotient; otherwise shift 0.
  - Go to FIX when count==0.
- FIX:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (C truncation semantics).
  - Load output_quotient_grant and output_remainder_grant, set output_grant_stb=1 and go to RESULT.
- RESULT:
  - Hold stb and data until output_grant_ack is high at an edge.
  - Then clear stb, update the last-served pointer to grant and go to ARB.
- Magnitudes are treated as unsigned 16-bit, so |−32768| = 0x8000.
- Divisor == 0: the quotient is 16'hFFFF and the remainder is the original dividend. Both bypass sign fix-up.
- −32768 / −1 gives quotient 16'h8000 and remainder 0. This is the natural wrap; no special case is needed.
- Outputs of the non-granted channel hold their last values, with stb low.

## Timing
- Reset values:
  - All *_ack and *_stb outputs are 0, and busy is 0.
  - output_quotient_n and output_remainder_n are 0.
  - State is ARB and the last-served pointer is 1.
- Reset during any state aborts the operation with no result. Asserting rst while output_n_stb is high drops stb on the next edge. A requester still holding stb is re-arbitrated from ARB after reset.
- Cycle timeline, counted from the ARB cycle in which a granted stb is sampled (cycle 0):

| Cycle | State | Observable |
|---|---|---|
| 1 | ACK | input_n_ack high |
| 2–17 | CALC | — |
| 18 | FIX | — |
| 19 | RESULT | output_n_stb first high |

- If output_n_ack is already high, the result transfers at the end of cycle 19 and ARB is cycle 20. Minimum throughput is 20 cycles per operation.
- Back-pressure stalls in RESULT for any number of cycles. The other channel is never acked during the stall.
- A stb deasserted before the grant is simply not served. Input data changes outside the ACK cycle are ignored.

## Test plan
- Channel 0, 100/7: input_0_ack high at cycle 1, output_0_stb at cycle 19, quotient 14, remainder 2. Channel 1 outputs untouched.
- Channel 1, −100/7: quotient 0xFFF2 (−14), remainder 0xFFFE (−2). Also 100/−7 gives −14 and 2.
- Simultaneous stb after reset with channel 0 20/3 and channel 1 −20/−3: channel 0 served first (6, 2), then channel 1 (6, 0xFFFE). A second simultaneous pair serves channel 1 first.
- Edge values:
  - 1234/0 gives 0xFFFF and 0x04D2.
  - −32768/−1 gives 0x8000 and 0.
  - 0/5 gives 0 and 0.
  - 32767/1 gives 32767 and 0.
- Hold output_0_ack low for 10 cycles with channel 1 requesting: output_0_stb and data stay stable, input_1_ack stays 0 and busy stays 1. After the ack, channel 1 is granted at the next ARB.
- Assert rst for 1 cycle mid-CALC: next cycle all stb/ack outputs are 0 and busy is 0. A channel 0 stb that is still held restarts and returns the correct result.

Source files
------------

// File: rtl/divider_scheduler.sv
// divider_scheduler: one 16-bit signed restoring divider shared round-robin
// between two requester channels, each with stb/ack operand and result handshakes.
module divider_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_dividend_0,
  input  logic [15:0] input_dividend_1,
  input  logic [15:0] input_divisor_0,
  input  logic [15:0] input_divisor_1,
  input  logic        input_0_stb,
  input  logic        input_1_stb,
  output logic        input_0_ack,
  output logic        input_1_ack,
  output logic [15:0] output_quotient_0,
  output logic [15:0] output_quotient_1,
  output logic [15:0] output_remainder_0,
  output logic [15:0] output_remainder_1,
  output logic        output_0_stb,
  output logic        output_1_stb,
  input  logic        output_0_ack,
  input  logic        output_1_ack,
  output logic        busy
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {ARB, ACK, CALC, FIX, RESULT} state_t;

  state_t          state, state_d;
  logic            grant, grant_d;
  logic            last, last_d;
  logic [W-1:0]    dvd, dvd_d;
  logic [W-1:0]    dvs, dvs_d;
  logic [W-1:0]    pr, pr_d;
  logic [W-1:0]    quo, quo_d;
  logic [CW-1:0]   count, count_d;
  logic            qsign, qsign_d;
  logic            rsign, rsign_d;
  logic            dzero, dzero_d;
  logic            ack0_d, ack1_d;
  logic            stb0_d, stb1_d;
  logic [W-1:0]    quot0_d, quot1_d, rem0_d, rem1_d;
  logic            busy_d;
  logic            sel;

  logic [W-1:0]    op_a, op_b;
  logic            res_ack;
  logic [W:0]      trial;
  logic [W-1:0]    q_fix, r_fix;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  assign op_a    = grant ? input_dividend_1 : input_dividend_0;
  assign op_b    = grant ? input_divisor_1  : input_divisor_0;
  assign res_ack = grant ? output_1_ack     : output_0_ack;
  assign trial   = {pr, dvd[W-1]};
  // Zero divisor leaves all-ones quotient; the remainder already equals |dividend|,
  // so restoring the dividend sign returns the original dividend.
  assign q_fix   = dzero ? '1 : (qsign ? (~quo + W'(1)) : quo);
  assign r_fix   = rsign ? (~pr + W'(1)) : pr;

  // Next-state, datapath and output-register next values
  always_comb begin
    state_d = state;
    grant_d = grant;
    last_d  = last;
    dvd_d   = dvd;
    dvs_d   = dvs;
    pr_d    = pr;
    quo_d   = quo;
    count_d = count;
    qsign_d = qsign;
    rsign_d = rsign;
    dzero_d = dzero;
    ack0_d  = input_0_ack;
    ack1_d  = input_1_ack;
    stb0_d  = output_0_stb;
    stb1_d  = output_1_stb;
    quot0_d = output_quotient_0;
    quot1_d = output_quotient_1;
    rem0_d  = output_remainder_0;
    rem1_d  = output_remainder_1;
    sel     = 1'b0;

    case (state)
      ARB: begin
        if (input_0_stb || input_1_stb) begin
          sel     = (input_0_stb && input_1_stb) ? ~last : input_1_stb;
          grant_d = sel;
          ack0_d  = ~sel;
          ack1_d  = sel;
          state_d = ACK;
        end
      end
      ACK: begin
        dvd_d   = mag(op_a);
        dvs_d   = mag(op_b);
        qsign_d = op_a[W-1] ^ op_b[W-1];
        rsign_d = op_a[W-1];
        dzero_d = (op_b == '0);
        pr_d    = '0;
        quo_d   = '0;
        count_d = CW'(15);
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = CALC;
      end
      CALC: begin
        dvd_d = {dvd[W-2:0], 1'b0};
        if (trial >= {1'b0, dvs}) begin
          pr_d  = W'(trial - {1'b0, dvs});
          quo_d = {quo[W-2:0], 1'b1};
        end else begin
          pr_d  = W'(trial);
          quo_d = {quo[W-2:0], 1'b0};
        end
        count_d = count - CW'(1);
        if (count == '0) state_d = FIX;
      end
      FIX: begin
        if (grant) begin
          quot1_d = q_fix;
          rem1_d  = r_fix;
          stb1_d  = 1'b1;
        end else begin
          quot0_d = q_fix;
          rem0_d  = r_fix;
          stb0_d  = 1'b1;
        end
        state_d = RESULT;
      end
      RESULT: begin
        if (res_ack) begin
          stb0_d  = 1'b0;
          stb1_d  = 1'b0;
          last_d  = grant;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    busy_d = (state_d != ARB);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ARB;
      grant              <= 1'b0;
      last               <= 1'b1;
      dvd                <= '0;
      dvs                <= '0;
      pr                 <= '0;
      quo                <= '0;
      count              <= '0;
      qsign              <= 1'b0;
      rsign              <= 1'b0;
      dzero              <= 1'b0;
      input_0_ack        <= 1'b0;
      input_1_ack        <= 1'b0;
      output_0_stb       <= 1'b0;
      output_1_stb       <= 1'b0;
      output_quotient_0  <= '0;
      output_quotient_1  <= '0;
      output_remainder_0 <= '0;
      output_remainder_1 <= '0;
      busy               <= 1'b0;
    end else begin
      state              <= state_d;
      grant              <= grant_d;
      last               <= last_d;
      dvd                <= dvd_d;
      dvs                <= dvs_d;
      pr                 <= pr_d;
      quo                <= quo_d;
      count              <= count_d;
      qsign              <= qsign_d;
      rsign              <= rsign_d;
      dzero              <= dzero_d;
      input_0_ack        <= ack0_d;
      input_1_ack        <= ack1_d;
      output_0_stb       <= stb0_d;
      output_1_stb       <= stb1_d;
      output_quotient_0  <= quot0_d;
      output_quotient_1  <= quot1_d;
      output_remainder_0 <= rem0_d;
      output_remainder_1 <= rem1_d;
      busy               <= busy_d;
    end
  end

endmodule

// File: tb/tb_divider_scheduler.sv
// Self-checking bench for divider_scheduler: scoreboard of expected results
// pushed when operands are driven and popped when a result handshake occurs.
module tb_divider_scheduler;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_dvd [2];
  logic [15:0] in_dvs [2];
  logic        in_stb [2];
  logic        out_ack [2];
  logic        in_ack0, in_ack1, out_stb0, out_stb1, busy;
  logic [15:0] oq0, oq1, or0, or1;

  res_t sb0[$];
  res_t sb1[$];
  time  done_t [2];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  divider_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .input_dividend_0   (in_dvd[0]),
    .input_dividend_1   (in_dvd[1]),
    .input_divisor_0    (in_dvs[0]),
    .input_divisor_1    (in_dvs[1]),
    .input_0_stb        (in_stb[0]),
    .input_1_stb        (in_stb[1]),
    .input_0_ack        (in_ack0),
    .input_1_ack        (in_ack1),
    .output_quotient_0  (oq0),
    .output_quotient_1  (oq1),
    .output_remainder_0 (or0),
    .output_remainder_1 (or1),
    .output_0_stb       (out_stb0),
    .output_1_stb       (out_stb1),
    .output_0_ack       (out_ack[0]),
    .output_1_ack       (out_ack[1]),
    .busy               (busy)
  );

  // Reference: C-style truncating division, zero divisor returns all-ones / dividend
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int   ai, bi;
    if (b == 16'd0) begin
      r.q = 16'hFFFF;
      r.r = a;
    end else begin
      ai  = int'($signed(a));
      bi  = int'($signed(b));
      r.q = 16'(ai / bi);
      r.r = 16'(ai % bi);
    end
    return r;
  endfunction

  function automatic logic get_in_ack(input int ch);
    return (ch == 0) ? in_ack0 : in_ack1;
  endfunction

  function automatic logic get_out_stb(input int ch);
    return (ch == 0) ? out_stb0 : out_stb1;
  endfunction

  function automatic res_t get_out(input int ch);
    res_t r;
    r.q = (ch == 0) ? oq0 : oq1;
    r.r = (ch == 0) ? or0 : or1;
    return r;
  endfunction

  task automatic send(input int ch, input logic [15:0] a, input logic [15:0] b);
    int n;
    if (ch == 0) sb0.push_back(model(a, b)); else sb1.push_back(model(a, b));
    in_dvd[ch] = a;
    in_dvs[ch] = b;
    in_stb[ch] = 1'b1;
    n = 0;
    while (!get_in_ack(ch) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (get_in_ack(ch) !== 1'b1) begin
      fails++;
      $display("FAIL send_ack ch%0d: input ack=%b, required 1 within 200 cycles", ch, get_in_ack(ch));
    end
    @(posedge clk); #1;
    in_stb[ch] = 1'b0;
    in_dvd[ch] = 16'($urandom);
    in_dvs[ch] = 16'($urandom);
  endtask

  task automatic receive(input int ch);
    int   n;
    res_t e, got;
    out_ack[ch] = 1'b1;
    n = 0;
    while (!get_out_stb(ch) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (get_out_stb(ch) !== 1'b1) begin
      fails++;
      $display("FAIL recv_stb ch%0d: output stb=%b, required 1 within 300 cycles", ch, get_out_stb(ch));
    end else begin
      got = get_out(ch);
      done_t[ch] = $time;
      checks++;
      if ((ch == 0 ? sb0.size() : sb1.size()) == 0) begin
        fails++;
        $display("FAIL recv_unexpected ch%0d: got q=%h r=%h, required no result", ch, got.q, got.r);
      end else begin
        e = (ch == 0) ? sb0.pop_front() : sb1.pop_front();
        if (got.q !== e.q || got.r !== e.r)  begin
          fails++;
          $display("FAIL recv_data ch%0d: got q=%h r=%h, required q=%h r=%h", ch, got.q, got.r, e.q, e.r);
        end
      end
    end
    @(posedge clk); #1;
    out_ack[ch] = 1'b0;
    checks++;
    if (get_out_stb(ch) !== 1'b0) begin
      fails++;
      $display("FAIL recv_drop ch%0d: output stb=%b after transfer, required 0", ch, get_out_stb(ch));
    end
  endtask

  task automatic do_op(input int ch, input logic [15:0] a, input logic [15:0] b);
    fork
      send(ch, a, b);
      receive(ch);
    join
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ack0, in_ack1, out_stb0, out_stb1, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ack/stb/busy=%b, required 00000", {in_ack0, in_ack1, out_stb0, out_stb1, busy});
    end
    checks++;
    if ({oq0, oq1, or0, or1} !== 64'd0) begin
      fails++;
      $display("FAIL reset_data: q0=%h q1=%h r0=%h r1=%h, required all 0", oq0, oq1, or0, or1);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    res_t e;
    sb0.push_back(model(16'd100, 16'd7));
    out_ack[0] = 1'b1;
    in_dvd[0] = 16'd100;
    in_dvs[0] = 16'd7;
    in_stb[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ack0 !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_ack_c1: ack0=%b busy=%b, required 1 1", in_ack0, busy);
    end
    @(posedge clk); #1;
    in_stb[0] = 1'b0;
    in_dvd[0] = 16'hBEEF;
    in_dvs[0] = 16'h0000;
    checks++;
    if (in_ack0 !== 1'b0) begin
      fails++;
      $display("FAIL single_ack_c2: ack0=%b, required 0", in_ack0);
    end
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (out_stb0 !== 1'b0) begin
      fails++;
      $display("FAIL single_stb_c18: stb0=%b, required 0", out_stb0);
    end
    @(posedge clk); #1;
    checks++;
    if (out_stb0 !== 1'b1) begin
      fails++;
      $display("FAIL single_stb_c19: stb0=%b, required 1", out_stb0);
    end
    e = sb0.pop_front();
    checks++;
    if (oq0 !== e.q || or0 !== e.r) begin
      fails++;
      $display("FAIL single_data: q=%h r=%h, required q=%h r=%h", oq0, or0, e.q, e.r);
    end
    checks++;
    if (out_stb1 !== 1'b0 || oq1 !== 16'd0 || or1 !== 16'd0) begin
      fails++;
      $display("FAIL single_ch1_idle: stb1=%b q1=%h r1=%h, required 0 0000 0000", out_stb1, oq1, or1);
    end
    @(posedge clk); #1;
    out_ack[0] = 1'b0;
    checks++;
    if (out_stb0 !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_c20: stb0=%b busy=%b, required 0 0", out_stb0, busy);
    end
  endtask

  task automatic test_signs;
    do_op(1, 16'hFF9C, 16'd7);
    do_op(0, 16'd100, 16'hFFF9);
    do_op(1, 16'hFF9C, 16'hFFF9);
  endtask

  task automatic test_tie;
    pulse_reset();
    fork
      send(0, 16'd20, 16'd3);
      send(1, 16'hFFEC, 16'hFFFD);
      receive(0);
      receive(1);
    join
    checks++;
    if (!(done_t[0] < done_t[1])) begin
      fails++;
      $display("FAIL tie_first: ch0 done %0t ch1 done %0t, required ch0 earlier", done_t[0], done_t[1]);
    end
    do_op(0, 16'd7, 16'd2);
    fork
      send(0, 16'd45, 16'd4);
      send(1, 16'd9, 16'hFFFE);
      receive(0);
      receive(1);
    join
    checks++;
    if (!(done_t[1] < done_t[0])) begin
      fails++;
      $display("FAIL tie_second: ch0 done %0t ch1 done %0t, required ch1 earlier", done_t[0], done_t[1]);
    end
  endtask

  task automatic test_edges;
    do_op(0, 16'd1234, 16'd0);
    do_op(1, 16'h8000, 16'hFFFF);
    do_op(0, 16'd0, 16'd5);
    do_op(1, 16'd32767, 16'd1);
    do_op(0, 16'h8000, 16'd0);
    do_op(1, 16'h8000, 16'd3);
  endtask

  task automatic test_backpressure;
    logic [15:0] hq, hr;
    res_t        e;
    int          n;
    out_ack[0] = 1'b0;
    send(0, 16'd500, 16'd9);
    fork
      send(1, 16'hFFB3, 16'd5);
      begin
        n = 0;
        while (!out_stb0 && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        checks++;
        if (out_stb0 !== 1'b1) begin
          fails++;
          $display("FAIL bp_stb: stb0=%b, required 1 within 100 cycles", out_stb0);
        end
        hq = oq0;
        hr = or0;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          checks++;
          if (out_stb0 !== 1'b1 || oq0 !== hq || or0 !== hr || in_ack1 !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold%0d: stb0=%b q=%h r=%h ack1=%b busy=%b, required 1 %h %h 0 1",
                     i, out_stb0, oq0, or0, in_ack1, busy, hq, hr);
          end
        end
        checks++;
        e = sb0.pop_front();
        if (hq !== e.q || hr !== e.r) begin
          fails++;
          $display("FAIL bp_data: q=%h r=%h, required q=%h r=%h", hq, hr, e.q, e.r);
        end
        out_ack[0] = 1'b1;
        @(posedge clk); #1;
        out_ack[0] = 1'b0;
        checks++;
        if (out_stb0 !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $display("FAIL bp_release: stb0=%b busy=%b, required 0 0", out_stb0, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ack1 !== 1'b1) begin
          fails++;
          $display("FAIL bp_next_grant: ack1=%b, required 1", in_ack1);
        end
      end
    join
    receive(1);
  endtask

  task automatic test_reset_mid;
    int n;
    in_dvd[0] = 16'hFC18;
    in_dvs[0] = 16'd33;
    in_stb[0] = 1'b1;
    n = 0;
    while (!in_ack0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ack0 !== 1'b1) begin
      fails++;
      $display("FAIL rmid_ack: ack0=%b, required 1", in_ack0);
    end
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ack0, in_ack1, out_stb0, out_stb1, busy} !== 5'b0) begin
      fails++;
      $display("FAIL rmid_abort: ack/stb/busy=%b, required 00000", {in_ack0, in_ack1, out_stb0, out_stb1, busy});
    end
    do_op(0, 16'hFC18, 16'd33);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_dvd[i]  = 16'd0;
      in_dvs[i]  = 16'd0;
      in_stb[i]  = 1'b0;
      out_ack[i] = 1'b0;
      done_t[i]  = 0;
    end
    #1;
    test_reset();
    test_single();
    test_signs();
    test_tie();
    test_edges();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: pending ch0=%0d ch1=%0d, required 0 0", sb0.size(), sb1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
